pwm_sample_sequencer: RTL and testbench

Sequences 4-bit two's-complement audio samples into the pwm_control datapath. Samples from the AXI data-transfer logic enter a small FIFO. The block presents exactly one sample per sample period on outsig, and changes outsig only at PWM frame boundaries so a frame never sees a mid-frame duty change. It handles priming, underrun and stop/flush. It sits between the AXI register/stream side and pwm_control in axi_datatran.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/sample_fifo.sv | 65 ++++++
 rtl/pwm_sample_sequencer.sv | 178 +++++++++++++++++
 tb/tb_pwm_sample_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Definitions shared by the PWM sample sequencer and its sample FIFO:
// the default frame length, sequencer state encodings and the silence code.
// ---------------------------------------------------------------------------
package pwm_pkg;

    // One PWM frame is one full period of the pwm_control counter (0..19)
    localparam int FRAME_LEN_DEF = 20;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } seqState_t;

    // Zero sample gives the 50%-offset duty, i.e. silence
    localparam logic [3:0] SILENCE = 4'd0;

endpackage

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Synchronous FIFO of 4-bit audio samples, depth 2**AW.
// Ports:
//   clk, globalresetn  clock and async active-low reset
//   push, din          write a sample (ignored while full)
//   pop, dout          read the head sample (ignored while empty); dout is
//                      the current head, valid whenever !empty
//   flush              return both pointers to zero, discarding contents
//   full, empty        occupancy flags
//   level              occupancy, 0..2**AW
// ---------------------------------------------------------------------------
module sample_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          globalresetn,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [3:0]    din,
    output logic [3:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;

    logic [AW:0] r_wrPtr;
    logic [AW:0] r_rdPtr;
    logic [3:0]  r_mem [DEPTH];
    logic        w_doPush;
    logic        w_doPop;

    // Pointers carry one extra bit so full and empty are distinguishable
    // when the address bits match
    assign full     = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign empty    = (r_wrPtr == r_rdPtr);
    assign level    = r_wrPtr - r_rdPtr;
    assign dout     = r_mem[r_rdPtr[AW-1:0]];
    assign w_doPush = push && !full && !flush;
    assign w_doPop  = pop && !empty && !flush;

    // Pointer update; flush discards everything including a same-cycle push
    always_ff @(posedge clk or negedge globalresetn) begin
        if (!globalresetn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    // Sample storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pwm_sample_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_sample_sequencer
// Buffers 4-bit two's-complement samples and hands one sample per sample
// period to pwm_control, changing outsig only at PWM frame boundaries.
// Ports:
//   clk, globalresetn  clock and async active-low reset (shared with pwm_control)
//   enable             play request, level-sensitive
//   s_data, s_valid    incoming sample; accepted when s_ready is high
//   s_ready            FIFO not full
//   clr_underrun       single-cycle clear of underrun_cnt
//   outsig             sample for pwm_control; 0 is silence
//   frame_start        pulse in the first cycle of each PWM frame
//   playing            high while in PLAY
//   fifo_level         FIFO occupancy
//   underrun_cnt       saturating count of underruns
// ---------------------------------------------------------------------------
module pwm_sample_sequencer
    import pwm_pkg::*;
#(
    parameter int FRAME_LEN         = FRAME_LEN_DEF,
    parameter int FRAMES_PER_SAMPLE = 4,
    parameter int FIFO_AW           = 4,
    parameter int PRIME_LEVEL       = 8
) (
    input  logic                 clk,
    input  logic                 globalresetn,
    input  logic                 enable,
    input  logic [3:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 clr_underrun,
    output logic [3:0]           outsig,
    output logic                 frame_start,
    output logic                 playing,
    output logic [FIFO_AW:0]     fifo_level,
    output logic [15:0]          underrun_cnt
);

    localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int SC_W = (FRAMES_PER_SAMPLE > 1) ? $clog2(FRAMES_PER_SAMPLE) : 1;

    logic [FC_W-1:0]    r_frameCnt;
    logic [SC_W-1:0]    r_subCnt;
    logic               r_frameStart;
    seqState_t          r_state;
    logic [3:0]         r_outsig;
    logic [15:0]        r_underrunCnt;
    logic [15:0]        w_underrunNext;

    logic               w_frameWrap;
    logic               w_subLast;
    logic               w_sampleTick;
    logic               w_full;
    logic               w_empty;
    logic [FIFO_AW:0]   w_level;
    logic [3:0]         w_head;
    logic               w_primed;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_underrun;

    assign w_frameWrap  = (r_frameCnt == FC_W'(FRAME_LEN - 1));
    assign w_subLast    = (r_subCnt == SC_W'(FRAMES_PER_SAMPLE - 1));
    assign w_sampleTick = w_frameWrap && w_subLast;
    assign w_primed     = (w_level >= (FIFO_AW + 1)'(PRIME_LEVEL));

    assign w_push     = s_valid && !w_full;
    // Leaving PRIME/PLAY empties the FIFO in the same cycle enable drops
    assign w_flush    = (r_state != IDLE) && !enable;
    // First pop happens on the tick that moves PRIME into PLAY
    assign w_pop      = w_sampleTick && enable && !w_empty &&
                        ((r_state == PLAY) || ((r_state == PRIME) && w_primed));
    assign w_underrun = w_sampleTick && enable && (r_state == PLAY) && w_empty;

    assign s_ready      = !w_full;
    assign outsig       = r_outsig;
    assign frame_start  = r_frameStart;
    assign playing      = (r_state == PLAY);
    assign fifo_level   = w_level;
    assign underrun_cnt = r_underrunCnt;

    sample_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk          (clk),
        .globalresetn (globalresetn),
        .push         (w_push),
        .pop          (w_pop),
        .flush        (w_flush),
        .din          (s_data),
        .dout         (w_head),
        .full         (w_full),
        .empty        (w_empty),
        .level        (w_level)
    );

    // Free-running frame and sub-frame counters, kept in step with the
    // pwm_control counter whatever the play state; frame_start is registered
    // from the wrap so it lands in the cycle the frame counter reads zero
    always_ff @(posedge clk or negedge globalresetn) begin
        if (!globalresetn) begin
            r_frameCnt   <= '0;
            r_subCnt     <= '0;
            r_frameStart <= 1'b0;
        end else begin
            r_frameStart <= w_frameWrap;
            if (w_frameWrap) begin
                r_frameCnt <= '0;
                r_subCnt   <= w_subLast ? '0 : r_subCnt + 1'b1;
            end else begin
                r_frameCnt <= r_frameCnt + 1'b1;
            end
        end
    end

    // Play state machine; outsig only ever moves on a sample tick so a
    // frame in progress never sees its duty change
    always_ff @(posedge clk or negedge globalresetn) begin
        if (!globalresetn) begin
            r_state  <= IDLE;
            r_outsig <= SILENCE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sampleTick) r_outsig <= SILENCE;
                    if (enable)       r_state  <= PRIME;
                end
                PRIME: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        if (w_sampleTick) r_outsig <= SILENCE;
                    end else if (w_sampleTick) begin
                        if (w_primed) begin
                            r_state  <= PLAY;
                            r_outsig <= w_head;
                        end else begin
                            r_outsig <= SILENCE;
                        end
                    end
                end
                PLAY: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        if (w_sampleTick) r_outsig <= SILENCE;
                    end else if (w_sampleTick) begin
                        if (!w_empty) begin
                            r_outsig <= w_head;
                        end else begin
                            r_outsig <= SILENCE;
                            r_state  <= PRIME;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_outsig <= SILENCE;
                end
            endcase
        end
    end

    // Underrun counter saturates; a clear in the same cycle as an underrun wins
    always_comb begin
        w_underrunNext = r_underrunCnt;
        if (clr_underrun) begin
            w_underrunNext = 16'd0;
        end else if (w_underrun && (r_underrunCnt != 16'hFFFF)) begin
            w_underrunNext = r_underrunCnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge globalresetn) begin
        if (!globalresetn) r_underrunCnt <= 16'd0;
        else               r_underrunCnt <= w_underrunNext;
    end

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pwm_sample_sequencer
// Directed bench for pwm_sample_sequencer. Timeline is expressed in clock
// cycles since reset release (cyc); with FRAME_LEN=20 and 4 frames per
// sample, a new outsig value becomes visible when cyc is a multiple of 80.
// ---------------------------------------------------------------------------
module tb_pwm_sample_sequencer;

    logic        clk;
    logic        globalresetn;
    logic        enable;
    logic [3:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        clr_underrun;
    logic [3:0]  outsig;
    logic        frame_start;
    logic        playing;
    logic [4:0]  fifo_level;
    logic [15:0] underrun_cnt;

    int totalChecks = 0;
    int badChecks   = 0;
    int cyc;

    pwm_sample_sequencer dut (
        .clk          (clk),
        .globalresetn (globalresetn),
        .enable       (enable),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .clr_underrun (clr_underrun),
        .outsig       (outsig),
        .frame_start  (frame_start),
        .playing      (playing),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle count since reset release, restarted by reset
    always @(posedge clk or negedge globalresetn) begin
        if (!globalresetn) cyc <= 0;
        else               cyc <= cyc + 1;
    end

    // Single comparison point for every check in this bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cyc %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    // Advance to the falling edge where cyc equals target
    task automatic gotoCyc(input int target);
        if (cyc > target) checkOutput("schedule", cyc, target);
        while (cyc < target) @(negedge clk);
    endtask

    // Offer n samples, one per cycle, with values (start+i) mod 16
    task automatic applyStimulus(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = 4'(start + i);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_data  = 4'd0;
    endtask

    initial begin
        globalresetn = 1'b0;
        enable       = 1'b0;
        s_valid      = 1'b0;
        s_data       = 4'd0;
        clr_underrun = 1'b0;
        repeat (3) @(negedge clk);
        globalresetn = 1'b1;

        // Idle: frame_start every 20 cycles, first one at cycle 20
        checkOutput("rstOutsig", outsig, 0);
        checkOutput("rstReady", s_ready, 1);
        checkOutput("rstLevel", fifo_level, 0);
        checkOutput("rstPlaying", playing, 0);
        checkOutput("rstUnderrun", underrun_cnt, 0);
        for (int n = 0; n < 100; n++) begin
            checkOutput("idleFrameStart", frame_start,
                        (n % 20 == 0 && n != 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        checkOutput("idleOutsig", outsig, 0);
        checkOutput("idleLevel", fifo_level, 0);
        checkOutput("idleReady", s_ready, 1);

        // Prime with 1..8, playback starts at the tick into cycle 160
        enable = 1'b1;
        applyStimulus(8, 1);
        checkOutput("primeLevel", fifo_level, 8);
        gotoCyc(159);
        checkOutput("primeOutsig", outsig, 0);
        checkOutput("primePlaying", playing, 0);
        for (int k = 1; k <= 8; k++) begin
            gotoCyc(160 + 80 * (k - 1));
            checkOutput("playOutsig", outsig, k);
            checkOutput("playFrameStart", frame_start, 1);
            if (k == 1) begin
                checkOutput("playPlaying", playing, 1);
                checkOutput("playLevel", fifo_level, 7);
            end
            gotoCyc(160 + 80 * (k - 1) + 79);
            checkOutput("playStable", outsig, k);
        end

        // Ninth tick finds the FIFO empty: underrun
        gotoCyc(800);
        checkOutput("urOutsig", outsig, 0);
        checkOutput("urCount", underrun_cnt, 1);
        checkOutput("urPlaying", playing, 0);

        // Refill with D,E,F,0,1,2,3,4 and resume cleanly
        applyStimulus(8, 13);
        gotoCyc(879);
        checkOutput("resumeSilent", outsig, 0);
        gotoCyc(880);
        checkOutput("resumeOutsig", outsig, 4'hD);
        checkOutput("resumePlaying", playing, 1);
        gotoCyc(960);
        checkOutput("resumeOutsig2", outsig, 4'hE);
        gotoCyc(1040);
        checkOutput("resumeOutsig3", outsig, 4'hF);

        // Drop enable mid-frame with five samples queued
        gotoCyc(1050);
        checkOutput("stopLevelBefore", fifo_level, 5);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("stopLevel", fifo_level, 0);
        checkOutput("stopPlaying", playing, 0);
        checkOutput("stopHold", outsig, 4'hF);
        gotoCyc(1119);
        checkOutput("stopHoldEnd", outsig, 4'hF);
        gotoCyc(1120);
        checkOutput("stopSilent", outsig, 0);
        checkOutput("stopUnderrun", underrun_cnt, 1);

        // Fill to 16 while idle; three more offers are refused
        applyStimulus(19, 1);
        checkOutput("fullLevel", fifo_level, 16);
        checkOutput("fullReady", s_ready, 0);
        enable = 1'b1;
        gotoCyc(1200);
        checkOutput("fullFirst", outsig, 1);
        checkOutput("fullLevelAfter", fifo_level, 15);
        checkOutput("fullReadyAfter", s_ready, 1);
        gotoCyc(1280);
        checkOutput("fullSecond", outsig, 2);

        // Flush then re-prime: first value must be fresh, not an old 3
        enable = 1'b0;
        @(negedge clk);
        checkOutput("flushLevel", fifo_level, 0);
        enable = 1'b1;
        applyStimulus(8, 1);
        for (int k = 1; k <= 8; k++) begin
            gotoCyc(1360 + 80 * (k - 1));
            checkOutput("replayOutsig", outsig, k);
        end

        // Saturation: preload the counter with FFFF before the next underrun
        gotoCyc(1990);
        force dut.r_underrunCnt = 16'hFFFF;
        gotoCyc(1992);
        release dut.r_underrunCnt;
        gotoCyc(1995);
        checkOutput("satPreload", underrun_cnt, 16'hFFFF);
        gotoCyc(2000);
        checkOutput("satCount", underrun_cnt, 16'hFFFF);
        checkOutput("satOutsig", outsig, 0);
        checkOutput("satPlaying", playing, 0);

        // Clear coinciding with an underrun: clear wins
        applyStimulus(8, 9);
        gotoCyc(2080);
        checkOutput("clrFirst", outsig, 9);
        gotoCyc(2719);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        checkOutput("clrCount", underrun_cnt, 0);
        checkOutput("clrPlaying", playing, 0);

        // Asynchronous reset mid-frame during playback
        applyStimulus(8, 3);
        gotoCyc(2800);
        checkOutput("preRstOutsig", outsig, 3);
        gotoCyc(2810);
        #2;
        globalresetn = 1'b0;
        #1;
        checkOutput("asyncOutsig", outsig, 0);
        checkOutput("asyncPlaying", playing, 0);
        checkOutput("asyncLevel", fifo_level, 0);
        checkOutput("asyncReady", s_ready, 1);
        checkOutput("asyncFrameStart", frame_start, 0);
        checkOutput("asyncUnderrun", underrun_cnt, 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        globalresetn = 1'b1;
        gotoCyc(19);
        checkOutput("postRstNoPulse", frame_start, 0);
        gotoCyc(20);
        checkOutput("postRstPulse", frame_start, 1);
        checkOutput("postRstLevel", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
